// File: rtl/sa_ctrl_pkg.sv
// Shared types and sizing helpers for the weight-stationary systolic array sequencer.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SETTLE,
        STREAM,
        DRAIN
    } sa_state_e;

    localparam int MIN_CNT_W = 1;

    // The phase counter must hold the vector count and the 2N+1 drain cycles.
    function automatic int cnt_width(input int m_w, input int n);
        int w;
        w = $clog2(2 * n + 1);
        if (m_w > w) w = m_w;
        if (w < MIN_CNT_W) w = MIN_CNT_W;
        return w;
    endfunction

endpackage

// File: rtl/skew_shift.sv
// N-tap delay line: tap i is the input delayed by i cycles, tap 0 is the input itself.
module skew_shift #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    output logic [N-1:0] taps
);

    generate
        if (N == 1) begin : g_single
            assign taps = din;
        end else begin : g_chain
            logic [N-2:0] q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else begin
                    q <= taps[N-2:0];
                end
            end

            assign taps = {q, din};
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Control sequencer for the N x N weight-stationary array: load weights, switch, stream, drain.
module systolic_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int N      = 4,
    parameter int M_W    = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [M_W-1:0]    num_vec,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              array_en,
    output logic              wbuf_rd_en,
    output logic [ADDR_W-1:0] wbuf_addr,
    output logic [N-1:0]      accept_w,
    output logic              ibuf_rd_en,
    output logic [ADDR_W-1:0] ibuf_addr,
    output logic [N-1:0]      row_switch,
    output logic [N-1:0]      row_valid,
    output logic [N-1:0]      col_out_valid
);

    localparam int CNT_W = cnt_width(M_W, N);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * N);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    sa_state_e        state;
    sa_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [M_W-1:0]   m_reg;
    logic [CNT_W-1:0] m_last;
    logic             switch_src;
    logic             valid_src;
    logic             col_src;

    assign m_last = CNT_W'(m_reg) - CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            m_reg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && state_nxt == LOAD_W) begin
                m_reg <= num_vec;
            end
        end
    end

    // ready gates acceptance so the first edge after reset release cannot start a job.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (ready && start && (num_vec != '0)) begin
                    state_nxt = LOAD_W;
                    cnt_nxt   = '0;
                end
            end
            LOAD_W: begin
                if (cnt == LOAD_LAST) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            SETTLE: begin
                state_nxt = STREAM;
                cnt_nxt   = '0;
            end
            STREAM: begin
                if (cnt == m_last) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are flopped from the next state so each lands in the cycle its phase occupies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            array_en   <= 1'b0;
            wbuf_rd_en <= 1'b0;
            wbuf_addr  <= '0;
            accept_w   <= '0;
            ibuf_rd_en <= 1'b0;
            ibuf_addr  <= '0;
            switch_src <= 1'b0;
            valid_src  <= 1'b0;
            col_src    <= 1'b0;
        end else begin
            ready      <= (state_nxt == IDLE);
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == DRAIN) && (cnt_nxt == DRAIN_LAST);
            array_en   <= (state_nxt != IDLE);
            wbuf_rd_en <= (state_nxt == LOAD_W);
            wbuf_addr  <= (state_nxt == LOAD_W) ? ADDR_W'(LOAD_LAST - cnt_nxt) : '0;
            accept_w   <= {N{wbuf_rd_en}};
            ibuf_rd_en <= (state_nxt == STREAM);
            ibuf_addr  <= (state_nxt == STREAM) ? ADDR_W'(cnt_nxt) : '0;
            switch_src <= (state_nxt == STREAM) && (cnt_nxt == '0);
            valid_src  <= ibuf_rd_en;
            col_src    <= row_valid[N-1];
        end
    end

    skew_shift #(.N(N)) u_switch_skew (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (switch_src),
        .taps (row_switch)
    );

    skew_shift #(.N(N)) u_valid_skew (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (valid_src),
        .taps (row_valid)
    );

    // Column strobes follow the last row's valid by one stage, then skew per column.
    skew_shift #(.N(N)) u_col_skew (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (col_src),
        .taps (col_out_valid)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: timing-table model plus directed literal checks.
module tb_systolic_ctrl;

    localparam int N      = 4;
    localparam int M_W    = 8;
    localparam int ADDR_W = 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [M_W-1:0]    num_vec = '0;
    logic              ready;
    logic              busy;
    logic              done;
    logic              array_en;
    logic              wbuf_rd_en;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [N-1:0]      accept_w;
    logic              ibuf_rd_en;
    logic [ADDR_W-1:0] ibuf_addr;
    logic [N-1:0]      row_switch;
    logic [N-1:0]      row_valid;
    logic [N-1:0]      col_out_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    systolic_ctrl #(.N(N), .M_W(M_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_vec      (num_vec),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .array_en     (array_en),
        .wbuf_rd_en   (wbuf_rd_en),
        .wbuf_addr    (wbuf_addr),
        .accept_w     (accept_w),
        .ibuf_rd_en   (ibuf_rd_en),
        .ibuf_addr    (ibuf_addr),
        .row_switch   (row_switch),
        .row_valid    (row_valid),
        .col_out_valid(col_out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit s, input int nv);
        start   = s;
        num_vec = M_W'(nv);
    endtask

    // Model: one job at a time, outputs derived from cycles elapsed since acceptance.
    bit m_clocked = 1'b0;
    bit m_job     = 1'b0;
    int m_cyc     = 0;
    int m_acc     = 0;
    int m_len     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clocked = 1'b0;
            m_job     = 1'b0;
        end else begin
            if (m_clocked && !m_job && start && (num_vec != 0)) begin
                m_job = 1'b1;
                m_acc = m_cyc;
                m_len = int'(num_vec);
            end
            m_cyc++;
            m_clocked = 1'b1;
            if (m_job && (m_cyc - m_acc) > 3 * N + m_len + 2) m_job = 1'b0;
        end
    end

    function automatic bit inr(input int rel, input int lo, input int hi);
        return m_job && (rel >= lo) && (rel <= hi);
    endfunction

    always @(negedge clk) begin : compare_proc
        int rel;
        int mm;
        int t0;
        logic [N-1:0] e_sw;
        logic [N-1:0] e_rv;
        logic [N-1:0] e_cv;
        rel = m_cyc - m_acc;
        mm  = m_len;
        t0  = N + 3;
        for (int i = 0; i < N; i++) begin
            e_sw[i] = inr(rel, N + 2 + i, N + 2 + i);
            e_rv[i] = inr(rel, t0 + i, t0 + i + mm - 1);
            e_cv[i] = inr(rel, t0 + N + i, t0 + N + i + mm - 1);
        end
        checkOutput("ready", int'(ready), int'(m_clocked && !m_job));
        checkOutput("busy", int'(busy), int'(m_clocked && m_job));
        checkOutput("array_en", int'(array_en), int'(inr(rel, 1, 3 * N + mm + 2)));
        checkOutput("done", int'(done), int'(inr(rel, 3 * N + mm + 2, 3 * N + mm + 2)));
        checkOutput("wbuf_rd_en", int'(wbuf_rd_en), int'(inr(rel, 1, N)));
        checkOutput("accept_w", int'(accept_w), inr(rel, 2, N + 1) ? (1 << N) - 1 : 0);
        checkOutput("ibuf_rd_en", int'(ibuf_rd_en), int'(inr(rel, N + 2, N + mm + 1)));
        checkOutput("row_switch", int'(row_switch), int'(e_sw));
        checkOutput("row_valid", int'(row_valid), int'(e_rv));
        checkOutput("col_out_valid", int'(col_out_valid), int'(e_cv));
        if (inr(rel, 1, N)) checkOutput("wbuf_addr", int'(wbuf_addr), N - rel);
        else if (!m_job) checkOutput("wbuf_addr_idle", int'(wbuf_addr), 0);
        if (inr(rel, N + 2, N + mm + 1)) checkOutput("ibuf_addr", int'(ibuf_addr), rel - (N + 2));
        else if (!m_job) checkOutput("ibuf_addr_idle", int'(ibuf_addr), 0);
    end

    int o_wa1, o_acc_first, o_sw0, o_sw3, o_rv0_first, o_rv3_last, o_cv0_first, o_cv3_last;
    int o_done_rel, o_done_cnt, o_en_low, o_wrd_cnt, o_wrd_last, o_ready_rel;

    // Runs a job from the current negedge and records event cycles relative to acceptance.
    task automatic observe(input int nv, input int upto, input int second_at, input int nv2);
        int a;
        int r;
        a = cyc;
        o_wa1 = -1; o_acc_first = -1; o_sw0 = -1; o_sw3 = -1;
        o_rv0_first = -1; o_rv3_last = -1; o_cv0_first = -1; o_cv3_last = -1;
        o_done_rel = -1; o_done_cnt = 0; o_en_low = 0; o_wrd_cnt = 0; o_wrd_last = -1;
        o_ready_rel = -1;
        r = 0;
        while (r <= upto) begin
            if (r == 0) applyStimulus(1'b1, nv);
            else if (r == second_at) applyStimulus(1'b1, nv2);
            else applyStimulus(1'b0, 0);
            if (r >= 1) begin
                if (r == 1) o_wa1 = int'(wbuf_addr);
                if (accept_w == '1 && o_acc_first < 0) o_acc_first = r;
                if (row_switch[0] && o_sw0 < 0) o_sw0 = r;
                if (row_switch[N-1] && o_sw3 < 0) o_sw3 = r;
                if (row_valid[0] && o_rv0_first < 0) o_rv0_first = r;
                if (row_valid[N-1]) o_rv3_last = r;
                if (col_out_valid[0] && o_cv0_first < 0) o_cv0_first = r;
                if (col_out_valid[N-1]) o_cv3_last = r;
                if (done) begin
                    o_done_cnt++;
                    if (o_done_rel < 0) o_done_rel = r;
                end
                if (!array_en) o_en_low++;
                if (wbuf_rd_en) begin
                    o_wrd_cnt++;
                    o_wrd_last = r;
                end
                if (ready && o_ready_rel < 0) o_ready_rel = r;
            end
            @(negedge clk);
            r = cyc - a;
        end
        applyStimulus(1'b0, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : directed
        int a;
        int dcount;
        applyStimulus(1'b1, 3);
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", int'(ready), 0);
        checkOutput("reset_array_en", int'(array_en), 0);
        checkOutput("reset_busy", int'(busy), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 0);
        checkOutput("post_reset_ready", int'(ready), 1);
        repeat (3) @(negedge clk);
        checkOutput("post_reset_no_accept", int'(array_en), 0);

        applyStimulus(1'b1, 0);
        repeat (3) @(negedge clk);
        checkOutput("zero_vec_ready", int'(ready), 1);
        checkOutput("zero_vec_array_en", int'(array_en), 0);
        applyStimulus(1'b0, 0);
        @(negedge clk);

        $display("[TB] job N=4 M=3");
        observe(3, 20, -1, 0);
        checkOutput("job1_wbuf_addr_c1", o_wa1, 3);
        checkOutput("job1_accept_w_first", o_acc_first, 2);
        checkOutput("job1_row_switch0", o_sw0, 6);
        checkOutput("job1_row_switch3", o_sw3, 9);
        checkOutput("job1_row_valid0_first", o_rv0_first, 7);
        checkOutput("job1_row_valid3_last", o_rv3_last, 12);
        checkOutput("job1_col_valid0_first", o_cv0_first, 11);
        checkOutput("job1_col_valid3_last", o_cv3_last, 16);
        checkOutput("job1_done_cycle", o_done_rel, 17);
        checkOutput("job1_ready_cycle", o_ready_rel, 18);
        checkOutput("job1_wbuf_rd_count", o_wrd_cnt, 4);

        $display("[TB] start pulsed during STREAM");
        observe(3, 30, 7, 5);
        checkOutput("busy_start_done_cycle", o_done_rel, 17);
        checkOutput("busy_start_done_count", o_done_cnt, 1);

        $display("[TB] reset during DRAIN");
        a = cyc;
        applyStimulus(1'b1, 3);
        @(negedge clk);
        applyStimulus(1'b0, 0);
        while (cyc - a < 12) @(negedge clk);
        checkOutput("pre_abort_col_valid0", int'(col_out_valid[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_col_out_valid", int'(col_out_valid), 0);
        checkOutput("abort_array_en", int'(array_en), 0);
        checkOutput("abort_ready", int'(ready), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checkOutput("abort_no_done", dcount, 0);
        observe(1, 18, -1, 0);
        checkOutput("m1_done_cycle", o_done_rel, 15);

        $display("[TB] back-to-back jobs");
        observe(3, 30, 18, 2);
        checkOutput("b2b_array_en_low", o_en_low, 1);
        checkOutput("b2b_wbuf_rd_count", o_wrd_cnt, 8);
        checkOutput("b2b_wbuf_rd_last", o_wrd_last, 22);
        checkOutput("b2b_first_done", o_done_rel, 17);
        repeat (25) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
